// File: rtl/cv32e40p_pmp_data_gate.sv
// PMP data gate: checks each LSU access against the PMP before it reaches OBI.
// Denied accesses get a local error response and are logged (first fault + count).
module cv32e40p_pmp_data_gate #(
  parameter int unsigned FAULT_CNT_W = 8,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  // LSU side
  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [31:0]            core_addr_i,
  input  logic                   core_we_i,
  input  logic [3:0]             core_be_i,
  input  logic [31:0]            core_wdata_i,
  output logic                   core_rvalid_o,
  output logic [31:0]            core_rdata_o,
  output logic                   core_err_o,
  // PMP check interface
  output logic [31:0]            pmp_addr_o,
  output logic                   pmp_we_o,
  input  logic                   pmp_access_i,
  // OBI side
  output logic                   bus_req_o,
  input  logic                   bus_gnt_i,
  output logic [31:0]            bus_addr_o,
  output logic                   bus_we_o,
  output logic [3:0]             bus_be_o,
  output logic [31:0]            bus_wdata_o,
  input  logic                   bus_rvalid_i,
  input  logic [31:0]            bus_rdata_i,
  input  logic                   bus_err_i,
  // fault capture
  output logic                   fault_valid_o,
  output logic [31:0]            fault_addr_o,
  output logic                   fault_we_o,
  input  logic                   fault_clr_i,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o
);

  typedef enum logic [2:0] {IDLE, CHECK, BUS_REQ, BUS_WAIT, RESP} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, wdata_q;
  logic [3:0]             be_q;
  logic                   we_q;
  logic                   req_load;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   rvalid_q, bus_req_q;
  logic                   deny;
  logic                   fault_valid_q;
  logic [31:0]            fault_addr_q;
  logic                   fault_we_q;
  logic [FAULT_CNT_W-1:0] fault_cnt_q;

  // Next-state and response-load decode
  always_comb begin
    state_d    = state_q;
    req_load   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    deny       = 1'b0;
    core_gnt_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        core_gnt_o = core_req_i;
        if (core_req_i) begin
          req_load = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (pmp_access_i) begin
          state_d = BUS_REQ;
        end else begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          deny    = 1'b1;
          state_d = RESP;
        end
      end
      BUS_REQ: begin
        if (bus_gnt_i) state_d = BUS_WAIT;
      end
      BUS_WAIT: begin
        if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          err_d   = bus_err_i;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered handshake outputs and response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      bus_req_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= (state_d == RESP);
      bus_req_q <= (state_d == BUS_REQ);
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Latch the accepted request; held for PMP and bus until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else if (req_load) begin
      addr_q  <= core_addr_i;
      we_q    <= core_we_i;
      be_q    <= core_be_i;
      wdata_q <= core_wdata_i;
    end
  end

  // First-fault capture and saturating deny counter; a new deny beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= 32'h0;
      fault_we_q    <= 1'b0;
      fault_cnt_q   <= '0;
    end else begin
      if (deny) begin
        if (fault_cnt_q != {FAULT_CNT_W{1'b1}}) begin
          fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
        end
        if (!fault_valid_q || fault_clr_i) begin
          fault_addr_q <= addr_q;
          fault_we_q   <= we_q;
        end
        fault_valid_q <= 1'b1;
      end else if (fault_clr_i) begin
        fault_valid_q <= 1'b0;
      end
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;
  assign pmp_addr_o    = addr_q;
  assign pmp_we_o      = we_q;
  assign bus_req_o     = bus_req_q;
  assign bus_addr_o    = addr_q;
  assign bus_we_o      = we_q;
  assign bus_be_o      = be_q;
  assign bus_wdata_o   = wdata_q;
  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_we_o    = fault_we_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_cv32e40p_pmp_data_gate.sv
// Directed bench for cv32e40p_pmp_data_gate with a response scoreboard queue.
module tb_cv32e40p_pmp_data_gate;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_i, core_gnt_o, core_we_i;
  logic [31:0]   core_addr_i, core_wdata_i;
  logic [3:0]    core_be_i;
  logic          core_rvalid_o, core_err_o;
  logic [31:0]   core_rdata_o;
  logic [31:0]   pmp_addr_o;
  logic          pmp_we_o, pmp_access_i;
  logic          bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i, bus_err_i;
  logic [31:0]   bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]    bus_be_o;
  logic          fault_valid_o, fault_we_o, fault_clr_i;
  logic [31:0]   fault_addr_o;
  logic [CW-1:0] fault_cnt_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    total = 0;
  int    bad   = 0;

  cv32e40p_pmp_data_gate #(.FAULT_CNT_W(CW), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .pmp_addr_o(pmp_addr_o), .pmp_we_o(pmp_we_o), .pmp_access_i(pmp_access_i),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
    .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .fault_valid_o(fault_valid_o), .fault_addr_o(fault_addr_o), .fault_we_o(fault_we_o),
    .fault_clr_i(fault_clr_i), .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for core_rvalid_o, check its cycle offset and the scoreboard entry
  task automatic wait_resp(input string tag, input int cyc_now, input int exp_cyc);
    int    n;
    int    guard;
    resp_t e;
    n     = cyc_now;
    guard = 0;
    while (core_rvalid_o !== 1'b1 && guard < 20) begin
      step();
      n++;
      guard++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_cyc));
    if (core_rvalid_o === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, core_rdata_o, e.rdata);
      chk({tag, "_err"}, 32'(core_err_o), 32'(e.err));
    end else begin
      chk({tag, "_resp_seen"}, 32'(core_rvalid_o), 32'(1));
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    step();
    chk({tag, "_rvalid_pulse"}, 32'(core_rvalid_o), 32'(0));
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
    chk({tag, "_breq"}, 32'(bus_req_o), 32'(1));
    chk({tag, "_baddr"}, bus_addr_o, a);
    chk({tag, "_bwe"}, 32'(bus_we_o), 32'(w));
    chk({tag, "_bbe"}, 32'(bus_be_o), 32'(b));
    chk({tag, "_bwdata"}, bus_wdata_o, d);
  endtask

  // One LSU transaction starting in IDLE; allowed ones see gnt after gnt_wait stall cycles
  // and rvalid one cycle after the first BUS_WAIT cycle
  task automatic txn(input string tag, input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] d, input logic allow, input int gnt_wait,
                     input logic [31:0] rd, input logic berr, input logic clr);
    resp_t e;
    int    n;
    e.rdata = allow ? rd : 32'h0000_0000;
    e.err   = allow ? berr : 1'b1;
    core_req_i = 1'b1; core_addr_i = a; core_we_i = w; core_be_i = b; core_wdata_i = d;
    pmp_access_i = allow;
    #1;
    chk({tag, "_gnt"}, 32'(core_gnt_o), 32'(1));
    sb_q.push_back(e);
    step();                                        // T+1: CHECK
    core_req_i = 1'b0;
    fault_clr_i = clr;
    chk({tag, "_pmp_addr"}, pmp_addr_o, a);
    chk({tag, "_pmp_we"}, 32'(pmp_we_o), 32'(w));
    chk({tag, "_breq_chk"}, 32'(bus_req_o), 32'(0));
    step();                                        // T+2
    fault_clr_i = 1'b0;
    if (!allow) begin
      chk({tag, "_no_breq"}, 32'(bus_req_o), 32'(0));
      wait_resp(tag, 2, 2);
    end else begin
      n = 2;
      for (int i = 0; i < gnt_wait; i++) begin
        chk_bus({tag, "_stall"}, a, w, b, d);
        core_req_i = 1'b1;
        bus_rvalid_i = (i == 1);
        bus_rdata_i = 32'hBAD0_BAD0;
        #1;
        chk({tag, "_busy_gnt"}, 32'(core_gnt_o), 32'(0));
        step();
        n++;
        core_req_i = 1'b0;
        bus_rvalid_i = 1'b0;
      end
      chk_bus(tag, a, w, b, d);
      bus_gnt_i = 1'b1;
      step();                                      // BUS_WAIT
      n++;
      bus_gnt_i = 1'b0;
      chk({tag, "_breq_drop"}, 32'(bus_req_o), 32'(0));
      step();
      n++;
      bus_rvalid_i = 1'b1; bus_rdata_i = rd; bus_err_i = berr;
      step();
      n++;
      bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
      wait_resp(tag, n, 5 + gnt_wait);
    end
  endtask

  initial begin
    rst = 1'b1;
    core_req_i = 1'b0; core_addr_i = 32'h0; core_we_i = 1'b0; core_be_i = 4'h0;
    core_wdata_i = 32'h0; pmp_access_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = 32'h0; bus_err_i = 1'b0; fault_clr_i = 1'b0;
    #12;
    chk("rst_rvalid", 32'(core_rvalid_o), 32'(0));
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_breq", 32'(bus_req_o), 32'(0));
    chk("rst_baddr", bus_addr_o, 32'h0);
    chk("rst_pmp_addr", pmp_addr_o, 32'h0);
    chk("rst_fvalid", 32'(fault_valid_o), 32'(0));
    chk("rst_fcnt", 32'(fault_cnt_o), 32'(0));
    rst = 1'b0;
    step();

    txn("rd_ok", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rd_ok_fcnt", 32'(fault_cnt_o), 32'(0));
    chk("rd_ok_fvalid", 32'(fault_valid_o), 32'(0));

    txn("wr_deny", 32'h2000_0004, 1'b1, 4'hF, 32'hCAFE_0001, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    chk("wr_deny_fvalid", 32'(fault_valid_o), 32'(1));
    chk("wr_deny_faddr", fault_addr_o, 32'h2000_0004);
    chk("wr_deny_fwe", 32'(fault_we_o), 32'(1));
    chk("wr_deny_fcnt", 32'(fault_cnt_o), 32'(1));

    txn("deny2", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    chk("deny2_faddr", fault_addr_o, 32'h2000_0004);
    chk("deny2_fwe", 32'(fault_we_o), 32'(1));
    chk("deny2_fcnt", 32'(fault_cnt_o), 32'(2));

    txn("deny_clr", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    chk("deny_clr_fvalid", 32'(fault_valid_o), 32'(1));
    chk("deny_clr_faddr", fault_addr_o, 32'h3000_0000);
    chk("deny_clr_fwe", 32'(fault_we_o), 32'(0));
    chk("deny_clr_fcnt", 32'(fault_cnt_o), 32'(3));

    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    chk("clr_fvalid", 32'(fault_valid_o), 32'(0));
    chk("clr_faddr_kept", fault_addr_o, 32'h3000_0000);
    chk("clr_fcnt_kept", 32'(fault_cnt_o), 32'(3));

    txn("bp", 32'h4000_0010, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 5, 32'h0000_00A5, 1'b0, 1'b0);
    chk("bp_fcnt", 32'(fault_cnt_o), 32'(3));

    // reset asserted while a request sits in BUS_REQ
    core_req_i = 1'b1; core_addr_i = 32'h5000_0000; core_we_i = 1'b0; core_be_i = 4'hF;
    pmp_access_i = 1'b1;
    step();
    core_req_i = 1'b0;
    step();
    chk("mid_breq", 32'(bus_req_o), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_breq", 32'(bus_req_o), 32'(0));
    chk("mid_rst_baddr", bus_addr_o, 32'h0);
    chk("mid_rst_rvalid", 32'(core_rvalid_o), 32'(0));
    chk("mid_rst_fcnt", 32'(fault_cnt_o), 32'(0));
    chk("mid_rst_faddr", fault_addr_o, 32'h0);
    step();
    rst = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    step();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    chk("stray_rvalid_a", 32'(core_rvalid_o), 32'(0));
    step();
    chk("stray_rvalid_b", 32'(core_rvalid_o), 32'(0));
    chk("post_rst_breq", 32'(bus_req_o), 32'(0));

    txn("berr", 32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b1, 0, 32'h1111_2222, 1'b1, 1'b0);
    chk("berr_fcnt", 32'(fault_cnt_o), 32'(0));
    chk("berr_fvalid", 32'(fault_valid_o), 32'(0));

    for (int k = 0; k < 5; k++) begin
      txn("sat", 32'h6000_0000 + 32'(k * 4), 1'b0, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      chk("sat_fcnt", 32'(fault_cnt_o), (k < 3) ? 32'(k + 1) : 32'(3));
      chk("sat_faddr", fault_addr_o, 32'h6000_0000);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_pmp_data_gate.md
Name: cv32e40p_pmp_data_gate

Overview:
- Sits between the LSU data port and the OBI data bus.
- Acts as the initiator side of the PMP check interface: for each accepted LSU request it drives the address and direction to the PMP checker and samples the access verdict.
- Allowed requests are forwarded to the bus. Denied requests never reach the bus; they get a local error response.
- Captures the first faulting access (for mtval) and keeps a saturating fault count. One transaction outstanding at a time.

Parameters:
FAULT_CNT_W, 8, width of saturating denied-access counter
ERR_RDATA, 32'h0000_0000, rdata returned on a denied access

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
core_req_i  in  1  LSU request
core_gnt_o  out  1  request accepted
core_addr_i  in  32  LSU address
core_we_i  in  1  LSU write enable
core_be_i  in  4  LSU byte enables
core_wdata_i  in  32  LSU write data
core_rvalid_o  out  1  response valid, one-cycle pulse
core_rdata_o  out  32  response read data
core_err_o  out  1  response error (bus error or PMP deny)
pmp_addr_o  out  32  address presented to PMP checker
pmp_we_o  out  1  direction presented to PMP checker
pmp_access_i  in  1  PMP verdict, 1 = allowed, combinational from pmp_addr_o/pmp_we_o
bus_req_o  out  1  OBI request
bus_gnt_i  in  1  OBI grant
bus_addr_o  out  32  OBI address
bus_we_o  out  1  OBI write enable
bus_be_o  out  4  OBI byte enables
bus_wdata_o  out  32  OBI write data
bus_rvalid_i  in  1  OBI response valid
bus_rdata_i  in  32  OBI read data
bus_err_i  in  1  OBI response error
fault_valid_o  out  1  sticky: a denied access has been captured
fault_addr_o  out  32  address of first captured denied access
fault_we_o  out  1  direction of first captured denied access
fault_clr_i  in  1  clears fault_valid_o
fault_cnt_o  out  FAULT_CNT_W  saturating count of denied accesses

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - Request/transaction registers: addr, we, be and wdata cleared to 0.
  - Outputs cleared to 0: core_rvalid_o, core_rdata_o, core_err_o, bus_req_o, fault_valid_o, fault_addr_o, fault_we_o, fault_cnt_o.
  - bus_addr_o/be_o/wdata_o/we_o and pmp_addr_o/pmp_we_o read 0 because they are driven from those registers.
  - Reset mid-transaction drops bus_req_o immediately. A later stray bus_rvalid_i is ignored.
- States: IDLE, CHECK, BUS_REQ, BUS_WAIT, RESP.
- IDLE:
  - core_gnt_o = core_req_i (combinational); core_gnt_o = 0 in every other state.
  - On core_req_i: register addr/we/be/wdata, go to CHECK.
- CHECK (exactly 1 cycle):
  - pmp_addr_o/pmp_we_o driven from the registered request, so they are stable in every non-IDLE state.
  - Sample pmp_access_i at the end of the cycle.
  - Allowed: go to BUS_REQ.
  - Denied: load rdata = ERR_RDATA and err = 1, go to RESP, update fault capture.
- BUS_REQ:
  - bus_req_o = 1; bus_addr/we/be/wdata come from the registers and are held stable until grant.
  - On bus_gnt_i: go to BUS_WAIT. bus_req_o is 0 the following cycle.
- BUS_WAIT:
  - bus_rvalid_i is sampled only in this state.
  - On bus_rvalid_i: register bus_rdata_i/bus_err_i, go to RESP.
  - bus_rvalid_i in any other state is ignored.
- RESP: core_rvalid_o = 1 for exactly one cycle with registered rdata/err, then return to IDLE.
- Latency, counted from the accept edge T (cycle with core_req_i && core_gnt_o):
  - Denied access: core_rvalid_o in cycle T+2.
  - Allowed access with gnt in its first bus cycle and rvalid one cycle later: bus_req_o in T+2, core_rvalid_o in T+5.
- Throughput: the earliest next grant is the cycle after RESP.
- Fault capture, on each denial in CHECK:
  - fault_cnt_o increments and saturates at all-ones.
  - If fault_valid_o == 0: capture addr/we and set fault_valid_o. Otherwise the first fault is kept.
  - fault_clr_i clears fault_valid_o only. fault_addr_o/fault_we_o keep their last captured value.
  - fault_clr_i in the same cycle as a denial: the new fault is captured and fault_valid_o stays 1.
  - fault_cnt_o is cleared only by reset.
- PMP-allowed accesses that get a bus error: core_err_o = 1, no fault capture, no count increment.

Test Plan:
- Reset: assert rst mid-BUS_REQ -> bus_req_o falls to 0 immediately; all outputs 0; FSM in IDLE; next request is granted normally.
- Allowed read: addr 0x0000_1000, pmp_access_i=1, bus_gnt_i in first BUS_REQ cycle, bus_rvalid_i next cycle with rdata 0xDEAD_BEEF -> bus_req_o in T+2; core_rvalid_o in T+5 with rdata 0xDEAD_BEEF, err 0; fault_cnt_o stays 0.
- Denied write: addr 0x2000_0004, we=1, pmp_access_i=0 -> bus_req_o never asserts; core_rvalid_o at T+2 with err=1, rdata=0; fault_valid_o=1, fault_addr_o=0x2000_0004, fault_we_o=1, fault_cnt_o=1.
- Second denial at 0x3000_0000 without clear -> fault_addr_o still 0x2000_0004, fault_cnt_o=2. Same denial again with fault_clr_i asserted in its CHECK cycle -> fault_valid_o=1, fault_addr_o=0x3000_0000.
- Bus backpressure: bus_gnt_i held low 5 cycles -> bus_req_o and bus_addr_o/be_o/wdata_o/we_o stable for all 5 cycles; core_gnt_o=0 for a new core_req_i; stray bus_rvalid_i during BUS_REQ is ignored.
- Saturation (FAULT_CNT_W=2): 5 consecutive denials -> fault_cnt_o reads 1, 2, 3, 3, 3. Separately, an allowed access with bus_err_i=1 -> core_err_o=1 and fault_cnt_o unchanged.
